// File: rtl/pipe_hazard_scoreboard.sv
// Hazard detection and forward-select unit: tracks destination tags and result
// latencies for DEPTH post-ID stages and stalls ID until each operand is forwardable.
module pipe_hazard_scoreboard #(
  parameter int AW    = 5,
  parameter int DEPTH = 4,
  parameter int SW    = 3,
  parameter int LW    = 3
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          id_valid,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic          use_rs,
  input  logic          use_rt,
  input  logic          wr_en,
  input  logic [AW-1:0] rd,
  input  logic [LW-1:0] lat,
  input  logic          ext_stall,
  input  logic          flush,
  output logic          stall,
  output logic          issue,
  output logic [SW-1:0] fwda,
  output logic [SW-1:0] fwdb,
  output logic          wb_valid,
  output logic [AW-1:0] wb_rn,
  output logic [31:0]   stall_cycles
);

  logic          v_p   [1:DEPTH];
  logic [AW-1:0] rn_p  [1:DEPTH];
  logic [LW-1:0] lat_p [1:DEPTH];
  logic          haz_a;
  logic          haz_b;

  function automatic logic [LW-1:0] clamp_lat(input logic [LW-1:0] l);
    if (l == '0)
      return LW'(1);
    else if (int'(l) > DEPTH)
      return LW'(DEPTH);
    else
      return l;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == '1) ? c : c + 32'd1;
  endfunction

  // ID stage: operand lookup, scanning oldest to youngest so the youngest match wins
  always_comb begin
    fwda  = '0;
    fwdb  = '0;
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (use_rs && rs != '0 && v_p[k] && rn_p[k] == rs) begin
        haz_a = (k < int'(lat_p[k]));
        fwda  = haz_a ? '0 : SW'(k);
      end
      if (use_rt && rt != '0 && v_p[k] && rn_p[k] == rt) begin
        haz_b = (k < int'(lat_p[k]));
        fwdb  = haz_b ? '0 : SW'(k);
      end
    end
  end

  assign stall    = id_valid & ~flush & (haz_a | haz_b);
  assign issue    = id_valid & ~stall & ~flush & ~ext_stall;
  assign wb_valid = v_p[DEPTH];
  assign wb_rn    = rn_p[DEPTH];

  // Stages 1..DEPTH: tag pipe advance and stall-cycle counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 1; k <= DEPTH; k++) begin
        v_p[k]   <= 1'b0;
        rn_p[k]  <= '0;
        lat_p[k] <= '0;
      end
      stall_cycles <= '0;
    end else if (!ext_stall) begin
      v_p[1]   <= issue & wr_en & (rd != '0);
      rn_p[1]  <= rd;
      lat_p[1] <= clamp_lat(lat);
      for (int k = 2; k <= DEPTH; k++) begin
        v_p[k]   <= v_p[k-1];
        rn_p[k]  <= rn_p[k-1];
        lat_p[k] <= lat_p[k-1];
      end
      if (stall)
        stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule

// File: doc/pipe_hazard_scoreboard.md
# pipe_hazard_scoreboard

Parametrised hazard-detection and forwarding-select unit for the pipelined MIPS core. It replaces fixed EXE/MEM forwarding with a DEPTH-stage destination-tag pipeline that carries a per-instruction result latency, so single-cycle ALU ops, loads and multi-cycle mul/div share one stall/forward scheme. It sits beside the ID-stage decoder: it takes source/destination register numbers of the instruction in ID and returns stall and per-operand forward selects. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- AW, 5: register-number width (2^AW architectural registers; register 0 is hard-wired zero).
- DEPTH, 4: number of post-ID stages tracked (stage 1 = EXE … stage DEPTH = last stage before regfile write). Legal range 2..7.
- SW, 3: forward-select width; must satisfy 2^SW > DEPTH.
- LW, 3: latency-field width; must satisfy 2^LW > DEPTH.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- rs, rt  in  AW each  source register numbers.
- use_rs, use_rt  in  1 each  instruction actually reads rs / rt.
- wr_en  in  1  instruction writes a register.
- rd  in  AW  destination register number.
- lat  in  LW  result latency: stage index at whose output the result is first forwardable (1 = ALU, 2 = load, up to DEPTH).
- ext_stall  in  1  global freeze (e.g. memory wait); whole pipe holds.
- flush  in  1  kill the instruction in ID (it enters as a bubble).
- stall  out  1  ID must hold; a bubble enters stage 1.
- issue  out  1  ID instruction accepted this cycle.
- fwda, fwdb  out  SW each  operand source: 0 = register file, k = output of stage k.
- wb_valid  out  1  stage DEPTH holds a register-writing instruction.
- wb_rn  out  AW  its destination register.
- stall_cycles  out  32  saturating count of hazard-stall cycles.

## Operation
- Tag pipe: stage k (1..DEPTH) holds {v, rn, lat} of the instruction that left ID k advancing cycles ago. Entries with rd = 0 or wr_en = 0 are stored with v = 0.
- Operand lookup (rs; rt identical): match at stage k if v[k] & rn[k] == rs & rs != 0. The youngest match (smallest k) wins; older matches are ignored.
  - No match or use_rs = 0: fwda = 0.
  - Winning k ≥ lat[k]: fwda = k.
  - Winning k < lat[k]: operand hazard.
- stall = id_valid & ~flush & (hazard on rs or hazard on rt). ext_stall does not gate stall.
- issue = id_valid & ~stall & ~flush & ~ext_stall.
- Advance when ext_stall = 0:
  - Stages 2..DEPTH take stage k-1 contents.
  - Stage 1 takes {wr_en & rd != 0, rd, lat} if issue is 1, else a bubble (v = 0).
- ext_stall = 1: every stage holds and no counter updates. fwda, fwdb and stall are recomputed combinationally from the held state.
- stall_cycles increments by 1 on each cycle with stall & ~ext_stall, saturating at 0xFFFFFFFF.
- wb_valid / wb_rn are taken directly from stage DEPTH.
- lat = 0 is treated as 1; lat > DEPTH is treated as DEPTH.

## Timing
- resetn low (asynchronous, any cycle including mid-stall): all v = 0, rn = 0, lat = 0, stall_cycles = 0. As a result fwda = fwdb = 0, stall = 0, wb_valid = 0, wb_rn = 0 with no clock edge required.
- fwda, fwdb, stall and issue are combinational from the ID inputs and registered state, with no added latency. State updates on the rising edge.
- Producer latency L followed immediately by a dependent instruction: max(L-1, 0) stall cycles, then forward from stage L.
- A write leaves the tag pipe DEPTH cycles after issue (excluding ext_stall cycles). After that its register is read from the regfile (select 0); the regfile must write-before-read.
- Simultaneous flush and hazard: flush wins. stall = 0 and a bubble enters stage 1.

## Test plan
- DEPTH=4. Issue add r3 (lat 1), then sub using rs=r3: fwda=1, stall=0, issue=1.
- lw r5 (lat 2), then use rt=r5: one cycle with stall=1, fwdb held at hazard. Next cycle fwdb=2, issue=1, stall_cycles=1.
- mul r7 (lat 4), then use r7 as both operands: stall for 3 cycles, then fwda=fwdb=4, stall_cycles=3. Raise ext_stall during stall cycle 2: state and outputs frozen, count unchanged.
- Writes r2 (lat 1) then r2 (lat 1) back-to-back, then reader of r2: fwda=1 (youngest match), not 2.
- Destination r0 with wr_en=1, then reader rs=r0: fwda=0, stall=0, wb_valid=0 when it reaches stage 4. Separately, a flush with a pending hazard gives stall=0, issue=0 and a bubble.
- Assert resetn low during a 4-cycle mul stall: stall=0, fwda=0, stall_cycles=0 immediately. After release the same reader issues with no stall (fwda=0).
